// File: rtl/bram_port_if.sv
// 32-bit BRAM-style port bundle shared by the RAM initiators and the responder.
interface bram_port_if;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic        ram_rst;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_rvalid;

   modport master (
      output ram_en, ram_we, ram_rst, ram_addr, ram_wdata,
      input  ram_rdata, ram_rvalid
   );

   modport slave (
      input  ram_en, ram_we, ram_rst, ram_addr, ram_wdata,
      output ram_rdata, ram_rvalid
   );
endinterface

// File: rtl/bram_port_responder.sv
// Memory-side responder for the BRAM-style port: byte-lane word store, 1- or 2-stage
// read pipeline, sticky address error flags and saturating access counters.
module bram_port_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned RD_LATENCY  = 1,
   parameter int unsigned WRITE_MODE  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stat_clr,
   bram_port_if.slave  bus,
   output logic        err_misalign,
   output logic        err_oor,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : gen_bad_cfg
      $error("bram_port_responder: RD_LATENCY must be 1 or 2");
   end

   logic [31:0]      mem_q [DEPTH_WORDS];
   logic [29:0]      off_w;
   logic [IDX_W-1:0] idx;
   logic             in_range;
   logic             acc_wr;
   logic [31:0]      old_word;
   logic [31:0]      merged;
   logic [31:0]      rd_result;

   assign off_w    = 30'((bus.ram_addr - BASE_ADDR) >> 2);
   assign idx      = off_w[IDX_W-1:0];
   assign in_range = (bus.ram_addr >= BASE_ADDR) && ({2'b00, off_w} < DEPTH_WORDS);
   assign acc_wr   = bus.ram_we != 4'h0;
   assign old_word = mem_q[idx];

   always_comb begin
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (bus.ram_we[b]) merged[8*b +: 8] = bus.ram_wdata[8*b +: 8];
      end
      rd_result = '0;
      if (in_range) rd_result = (WRITE_MODE != 0) ? merged : old_word;
   end

   // Array is deliberately not reset; contents survive rst_n.
   always_ff @(posedge clk) begin
      if (bus.ram_en && acc_wr && in_range) mem_q[idx] <= merged;
   end

   logic        fin_vld;
   logic [31:0] fin_data;

   if (RD_LATENCY == 2) begin : gen_lat2
      logic        s1_vld_q;
      logic [31:0] s1_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
         end else begin
            s1_vld_q <= bus.ram_en;
            if (bus.ram_en) s1_data_q <= rd_result;
         end
      end

      assign fin_vld  = s1_vld_q;
      assign fin_data = s1_data_q;
   end else begin : gen_lat1
      assign fin_vld  = bus.ram_en;
      assign fin_data = rd_result;
   end

   logic [31:0] rdata_d, rdata_q;
   logic        rvalid_d, rvalid_q;

   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (bus.ram_rst) begin
         rdata_d = '0;
      end else if (fin_vld) begin
         rdata_d  = fin_data;
         rvalid_d = 1'b1;
      end
   end

   logic        mis_d, mis_q, oor_d, oor_q;
   logic [15:0] rdc_d, rdc_q, wrc_d, wrc_q;

   // Clear wins over a simultaneous access, which is then neither counted nor flagged.
   always_comb begin
      mis_d = mis_q;
      oor_d = oor_q;
      rdc_d = rdc_q;
      wrc_d = wrc_q;
      if (stat_clr) begin
         mis_d = 1'b0;
         oor_d = 1'b0;
         rdc_d = '0;
         wrc_d = '0;
      end else if (bus.ram_en) begin
         if (bus.ram_addr[1:0] != 2'b00) mis_d = 1'b1;
         if (!in_range) oor_d = 1'b1;
         if (!acc_wr) begin
            if (rdc_q != 16'hFFFF) rdc_d = rdc_q + 16'd1;
         end else begin
            if (wrc_q != 16'hFFFF) wrc_d = wrc_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
         oor_q    <= 1'b0;
         rdc_q    <= '0;
         wrc_q    <= '0;
      end else begin
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         mis_q    <= mis_d;
         oor_q    <= oor_d;
         rdc_q    <= rdc_d;
         wrc_q    <= wrc_d;
      end
   end

   assign bus.ram_rdata  = rdata_q;
   assign bus.ram_rvalid = rvalid_q;
   assign err_misalign   = mis_q;
   assign err_oor        = oor_q;
   assign rd_count       = rdc_q;
   assign wr_count       = wrc_q;

endmodule
